// File: rtl/uart_tx_fifo_sequencer_if.sv
// Bundle of the TX FIFO read side and the UART TX shift-engine handshake.
// The master modport is the sequencer. The slave modport is the FIFO plus the transmitter.
interface uart_tx_fifo_sequencer_if #(
  parameter int DATA_BITS = 8
);
  // Handshake semantics:
  // - fifo_data_out is valid whenever fifo_empty_flag is 0.
  // - A cycle with fifo_read_flag high consumes the head word at that clock edge.
  // - tx_start is a one-cycle request and tx_data is valid with it.
  // - The transmitter holds tx_busy while shifting and pulses tx_done for one cycle at frame end.
  logic                 fifo_empty_flag;
  logic [DATA_BITS-1:0] fifo_data_out;
  logic                 fifo_read_flag;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;

  modport master (
    input  fifo_empty_flag,
    input  fifo_data_out,
    input  tx_busy,
    input  tx_done,
    output fifo_read_flag,
    output tx_start,
    output tx_data
  );

  modport slave (
    output fifo_empty_flag,
    output fifo_data_out,
    output tx_busy,
    output tx_done,
    input  fifo_read_flag,
    input  tx_start,
    input  tx_data
  );
endinterface

// File: rtl/uart_tx_fifo_sequencer.sv
// Drains the UART TX FIFO into the transmitter one byte per frame.
// Also provides an optional inter-frame gap, a FIFO flush, a tx_done watchdog and a sent-frame counter.
module uart_tx_fifo_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  uart_tx_fifo_sequencer_if.master   bus,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           sent_count,
  output logic [2:0]                 state_dbg
);

  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // The watchdog is zeroed in START. Expiring at TIMEOUT-2 raises the error exactly TIMEOUT clocks after tx_start.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_GAP     = 3'd4,
    S_FLUSH   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]     sent_count_q, sent_count_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 flush_pop;

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;
    sent_count_d  = sent_count_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    flush_pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush && !bus.fifo_empty_flag) begin
          state_d = S_FLUSH;
        end else if (enable && !bus.fifo_empty_flag && !bus.tx_busy) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = bus.fifo_data_out;
        state_d   = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // A tx_done arriving on the expiry clock still counts as a good frame.
        if (bus.tx_done) begin
          sent_count_d = sent_count_q + CNT_W'(1);
          gap_d        = '0;
          state_d      = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_FLUSH: begin
        if (!flush || bus.fifo_empty_flag) begin
          state_d = S_IDLE;
        end else begin
          flush_pop = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      sent_count_q  <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      sent_count_q  <= sent_count_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
    end
  end

  // During a flush the pop is gated by the live empty flag, so an emptied FIFO is never popped again.
  assign bus.fifo_read_flag = (state_q == S_LOAD) || flush_pop;
  assign bus.tx_start       = tx_start_q;
  assign bus.tx_data        = tx_data_q;
  assign busy               = busy_q;
  assign timeout_err        = timeout_err_q;
  assign sent_count         = sent_count_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Scoreboard bench for uart_tx_fifo_sequencer with a queue-based FIFO and a transmitter responder.
// Expected bytes, frame counts, gap timing and watchdog timing come from a cycle-level reference.
module tb_uart_tx_fifo_sequencer;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TMO = 16;
  localparam int CW  = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic busy, timeout_err;
  logic [CW-1:0] sent_count;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  uart_tx_fifo_sequencer_if #(.DATA_BITS(DW)) bus ();

  uart_tx_fifo_sequencer #(
    .DATA_BITS(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .bus(bus),
    .busy(busy), .timeout_err(timeout_err), .sent_count(sent_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_q[$];
  int cyc = 0;
  bit outstanding = 0;
  int t0 = 0;
  int done_at = 0;
  bit tx_mute = 0;
  int fixed_delay = 0;
  int ref_sent = 0;
  bit exp_terr = 0;
  bit pop_pend = 0;
  bit done_pend = 0;
  bit start_pend = 0;
  bit in_flush = 0;
  int flush_pops = 0;
  int first_flush = -1;
  int last_flush = -1;
  bit gap_armed = 0;
  int gap_exp = 0;
  int starts = 0;
  logic [DW-1:0] last_sent = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor + FIFO/transmitter model ----------------
  initial begin
    bit exp_start;
    bus.tx_done = 1'b0;
    bus.tx_busy = 1'b0;
    bus.fifo_empty_flag = 1'b1;
    bus.fifo_data_out = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        fifo_q.delete();
        wr_q.delete();
        pop_pend = 0; outstanding = 0; done_pend = 0; start_pend = 0;
        gap_armed = 0; exp_terr = 0; ref_sent = 0;
        bus.tx_done = 1'b0;
        bus.tx_busy = 1'b0;
        bus.fifo_empty_flag = 1'b1;
        bus.fifo_data_out = '0;
        continue;
      end
      if (pop_pend) begin
        void'(fifo_q.pop_front());
        pop_pend = 0;
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      bus.fifo_empty_flag = (fifo_q.size() == 0);
      bus.fifo_data_out = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      #1;
      if (done_pend) begin
        ref_sent++;
        done_pend = 0;
      end
      check("sent_count", 32'(sent_count), 32'(ref_sent % (1 << CW)));
      if (outstanding && (cyc - t0 == TMO)) begin
        exp_terr = 1;
        outstanding = 0;
        bus.tx_busy = 1'b0;
      end
      check("timeout_err", 32'(timeout_err), 32'(exp_terr));

      exp_start = start_pend;
      start_pend = bus.fifo_read_flag && !in_flush;
      if (bus.fifo_read_flag) begin
        pop_pend = 1;
        check("read_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        check("read_busy", 32'(busy), 32'd1);
        if (in_flush) begin
          flush_pops++;
          if (first_flush < 0) first_flush = cyc;
          last_flush = cyc;
        end else if (gap_armed) begin
          check("gap_to_read", 32'(cyc), 32'(gap_exp));
          gap_armed = 0;
        end
      end
      if (bus.tx_start || exp_start) check("start_after_read", 32'(bus.tx_start), 32'(exp_start));

      bus.tx_done = 1'b0;
      if (bus.tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx_data 0x%0h expected no frame", bus.tx_data);
        end else begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        check("start_busy", 32'(busy), 32'd1);
        last_sent = bus.tx_data;
        outstanding = 1;
        t0 = cyc;
        done_at = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(2, 12)));
        if (!tx_mute) bus.tx_busy = 1'b1;
        starts++;
      end else if (outstanding && !tx_mute && cyc == done_at) begin
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
        outstanding = 0;
        done_pend = 1;
        check("tx_data_hold", 32'(bus.tx_data), 32'(last_sent));
        if (enable && !flush && fifo_q.size() > 0) begin
          gap_armed = 1;
          gap_exp = cyc + GAP + 2;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic push_byte(input logic [DW-1:0] b, input bit expect_tx);
    wr_q.push_back(b);
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || outstanding || wr_q.size() > 0) && n < budget) begin
      wait_cycles(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timed out with %0d bytes left, required 0", name, exp_q.size());
    end
    wait_cycles(GAP + 4);
  endtask

  task automatic wait_start(input string name);
    int s0 = starts;
    int n = 0;
    while (starts == s0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    if (starts == s0) begin
      checks++;
      errors++;
      $display("FAIL %s: no tx_start within 200 cycles, required one", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_read", 32'(bus.fifo_read_flag), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_sent_count", 32'(sent_count), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);

    // three ordered bytes with a 10-clock frame time
    fixed_delay = 10;
    push_byte(8'h01, 1);
    push_byte(8'h02, 1);
    push_byte(8'h03, 1);
    enable = 1'b1;
    wait_drain("ordered_three", 300);
    check("ordered_sent", 32'(sent_count), 32'd3);
    check("ordered_idle_busy", 32'(busy), 32'd0);

    // random bytes arriving at random times with random frame times
    fixed_delay = 0;
    for (int i = 0; i < 6; i++) begin
      push_byte(DW'($urandom_range(0, 255)), 1);
      wait_cycles($urandom_range(0, 20));
    end
    wait_drain("random_six", 600);
    check("random_idle_busy", 32'(busy), 32'd0);

    // enable dropped mid-frame: current frame finishes, the next byte waits
    push_byte(DW'($urandom_range(0, 255)), 1);
    push_byte(DW'($urandom_range(0, 255)), 1);
    wait_start("enable_drop_start");
    enable = 1'b0;
    wait_cycles(40);
    check("enable_drop_busy", 32'(busy), 32'd0);
    check("enable_drop_left", 32'(fifo_q.size()), 32'd1);
    enable = 1'b1;
    wait_drain("enable_resume", 300);

    // flush of four bytes with enable low
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(DW'($urandom_range(0, 255)), 0);
    wait_cycles(2);
    in_flush = 1;
    flush_pops = 0;
    first_flush = -1;
    flush = 1'b1;
    n = 0;
    while ((fifo_q.size() > 0 || pop_pend) && n < 50) begin
      wait_cycles(1);
      n++;
    end
    wait_cycles(3);
    flush = 1'b0;
    wait_cycles(2);
    in_flush = 0;
    check("flush_pops", 32'(flush_pops), 32'd4);
    check("flush_consecutive", 32'(last_flush - first_flush), 32'd3);
    check("flush_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("flush_idle_busy", 32'(busy), 32'd0);

    // watchdog: transmitter never answers, then a normal frame follows
    tx_mute = 1;
    enable = 1'b1;
    push_byte(DW'($urandom_range(0, 255)), 1);
    n = 0;
    while (!exp_terr && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check("watchdog_fired", 32'(timeout_err), 32'd1);
    tx_mute = 0;
    wait_cycles(3);
    push_byte(DW'($urandom_range(0, 255)), 1);
    wait_drain("after_timeout", 300);
    check("after_timeout_sent", 32'(sent_count), 32'd12);

    // eight more frames: 20 frames in total wraps a 4-bit counter to 4
    for (int i = 0; i < 8; i++) push_byte(DW'($urandom_range(0, 255)), 1);
    wait_drain("wrap_frames", 800);
    check("sent_count_wrapped", 32'(sent_count), 32'd4);

    // asynchronous reset in the middle of a frame
    push_byte(DW'($urandom_range(0, 255)), 1);
    push_byte(DW'($urandom_range(0, 255)), 1);
    wait_start("reset_mid_frame_start");
    wait_cycles(3);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check("midrst_read", 32'(bus.fifo_read_flag), 32'd0);
    check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    check("midrst_sent_count", 32'(sent_count), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    exp_q.delete();
    wr_q.delete();
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(10);
    check("post_reset_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end
endmodule
